soma_gradiente: RTL and testbench
=================================

SOMA_GRADIENTE -- requirements
Module: soma_gradiente

Interface
REQ-001 SHALL have parameter THRESHOLD, default 128, giving the binarisation level used only when EDGE_THRESHOLD_EN is defined.
REQ-002 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request; honoured only in S_IDLE.
REQ-005 SHALL have port products_x  input  400  25 signed 16-bit Gx kernel products; element j in bits [16j+15:16j].
REQ-006 SHALL have port products_y  input  400  25 signed 16-bit Gy kernel products, packed the same way.
REQ-007 SHALL have port pixel_out  output  8  unsigned edge pixel result.
REQ-008 SHALL have port gx_sum  output  21  signed final Gx sum.
REQ-009 SHALL have port gy_sum  output  21  signed final Gy sum.
REQ-010 SHALL have port busy  output  1  high in every state other than S_IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking valid outputs.

Function
REQ-012 SHALL implement states S_IDLE, S_ACC and S_OUT.
REQ-013 In S_IDLE, start=1 SHALL capture both product vectors into internal registers, clear both accumulators and index, and go to S_ACC; upstream may change its inputs afterwards.
REQ-014 S_ACC SHALL add sign-extended element[index] of each captured vector into its 21-bit signed accumulator, one element per clock, index 0..24.
REQ-015 After index 24, S_ACC SHALL go to S_OUT.
REQ-016 S_OUT SHALL compute mag = |gx| + |gy| as a 22-bit unsigned value, register pixel_out, gx_sum and gy_sum, pulse done, and return to S_IDLE.
REQ-017 Without EDGE_THRESHOLD_EN, pixel_out SHALL be min(mag, 255).
REQ-018 Latency SHALL be fixed: with start sampled at edge 0, done SHALL be high from edge 26 to edge 27.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 start held high SHALL launch a new operation at the first edge spent in S_IDLE.
REQ-021 The 21-bit accumulators SHALL never overflow: the worst case is 25*32640 = 816000.
REQ-022 |-2^20| SHALL NOT occur, because inputs are bounded by REQ-021.
REQ-023 pixel_out, gx_sum and gy_sum SHALL hold their values until the next S_OUT or reset.
REQ-024 done SHALL be low in all cycles except the single S_OUT-exit cycle.

Reset
REQ-025 reset=1 SHALL immediately force S_IDLE and set pixel_out=0, gx_sum=0, gy_sum=0, busy=0, done=0, index=0 and both accumulators to 0.
REQ-026 Reset mid-operation SHALL abort the operation with no done pulse.
REQ-027 start asserted in the first edge after reset release SHALL be honoured.

Configuration
REQ-028 Macro EDGE_THRESHOLD_EN defined: pixel_out SHALL be 255 when mag > THRESHOLD, else 0.
REQ-029 Macro EDGE_THRESHOLD_EN absent: saturated magnitude per REQ-017, and THRESHOLD unused.
REQ-030 Timing and all other outputs SHALL be identical in both builds.

Structure
REQ-031 Shared package SHALL hold N_ELEM=25, ELEM_W=16, ACC_W=21, MAG_W=22, PIX_W=8 and the state encoding.
REQ-032 The abs/sum/clamp/threshold logic SHALL be a combinational sub-module magnitude_clamp (inputs gx, gy; output pixel).
REQ-033 All sequencing SHALL remain in soma_gradiente.

Verification
REQ-034 All products_x=+1, products_y=0, start pulse: done at edge 26; gx_sum=25, gy_sum=0, pixel_out=25.
REQ-035 products_x all -32640, products_y all +32640: gx_sum=-816000, gy_sum=816000, pixel_out=255; with EDGE_THRESHOLD_EN, pixel_out=255.
REQ-036 products_x element0=+100 and element24=-40, products_y element12=-30, THRESHOLD=128, EDGE_THRESHOLD_EN: gx=60, gy=-30, mag=90, pixel_out=0; without the macro, pixel_out=90.
REQ-037 Inputs changed and start re-pulsed at edge 5 of an operation: the second start is ignored and the result reflects the vectors captured at edge 0.
REQ-038 reset asserted at edge 12: busy=0 and done=0 immediately, no done pulse; a new start then completes normally with a 26-cycle latency.
REQ-039 start held high continuously: a done pulse every 27 clocks, with back-to-back results correct.

Source files
------------

// File: rtl/soma_gradiente_pkg.sv
// Shared constants, state encoding and sign-extension helper for the gradient summer.
package soma_gradiente_pkg;

   localparam int unsigned N_ELEM = 25;
   localparam int unsigned ELEM_W = 16;
   localparam int unsigned ACC_W  = 21;
   localparam int unsigned MAG_W  = 22;
   localparam int unsigned PIX_W  = 8;
   localparam int unsigned IDX_W  = 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   // Widen one kernel product to accumulator width, keeping its sign.
   function automatic logic signed [ACC_W-1:0] sext_elem(input logic [ELEM_W-1:0] e);
      return $signed({{(ACC_W-ELEM_W){e[ELEM_W-1]}}, e});
   endfunction

endpackage

// File: rtl/magnitude_clamp.sv
// Combinational |gx| + |gy| followed by either saturation to 8 bits (default)
// or binarisation against THRESHOLD when EDGE_THRESHOLD_EN is defined.
module magnitude_clamp
   import soma_gradiente_pkg::*;
#(
   parameter int unsigned THRESHOLD = 128
) (
   input  logic signed [ACC_W-1:0] gx,
   input  logic signed [ACC_W-1:0] gy,
   output logic        [PIX_W-1:0] pixel
);

   localparam logic [MAG_W-1:0] PIX_MAX = MAG_W'((1 << PIX_W) - 1);

   logic signed [MAG_W-1:0] gx_ext, gy_ext;
   logic        [MAG_W-1:0] abs_x, abs_y, mag;

   // Extend by one bit before negating so abs never wraps, then sum and map to a pixel.
   always_comb begin
      gx_ext = {gx[ACC_W-1], gx};
      gy_ext = {gy[ACC_W-1], gy};
      abs_x  = gx_ext[MAG_W-1] ? -gx_ext : gx_ext;
      abs_y  = gy_ext[MAG_W-1] ? -gy_ext : gy_ext;
      mag    = abs_x + abs_y;
`ifdef EDGE_THRESHOLD_EN
      pixel  = (mag > MAG_W'(THRESHOLD)) ? '1 : '0;
`else
      pixel  = (mag > PIX_MAX) ? '1 : mag[PIX_W-1:0];
`endif
   end

`ifndef EDGE_THRESHOLD_EN
   logic unused_threshold;
   assign unused_threshold = ^THRESHOLD;
`endif

endmodule

// File: rtl/soma_gradiente.sv
// Sequential Gx/Gy summer: captures 25 kernel products per axis on start, accumulates
// one element per clock, then registers the edge pixel and both sums with a done pulse.
// Optional build macro: EDGE_THRESHOLD_EN (binarised pixel output).
module soma_gradiente
   import soma_gradiente_pkg::*;
#(
   parameter int unsigned THRESHOLD = 128
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            start,
   input  logic        [N_ELEM*ELEM_W-1:0] products_x,
   input  logic        [N_ELEM*ELEM_W-1:0] products_y,
   output logic        [PIX_W-1:0]         pixel_out,
   output logic signed [ACC_W-1:0]         gx_sum,
   output logic signed [ACC_W-1:0]         gy_sum,
   output logic                            busy,
   output logic                            done
);

   state_t                  state_q, state_d;
   logic [ELEM_W-1:0]       elem_x_q [N_ELEM];
   logic [ELEM_W-1:0]       elem_y_q [N_ELEM];
   logic [IDX_W-1:0]        index_q;
   logic signed [ACC_W-1:0] acc_x_q, acc_y_q;
   logic [PIX_W-1:0]        pixel_d;
   logic                    launch;

   assign launch = (state_q == S_IDLE) && start;
   assign busy   = (state_q != S_IDLE);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state: one pass of 25 accumulate cycles, then a single output cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_ACC;
         S_ACC:   if (index_q == IDX_W'(N_ELEM - 1)) state_d = S_OUT;
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Snapshot both product vectors so upstream is free to move on after start.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int j = 0; j < N_ELEM; j++) begin
            elem_x_q[j] <= '0;
            elem_y_q[j] <= '0;
         end
      end else if (launch) begin
         for (int j = 0; j < N_ELEM; j++) begin
            elem_x_q[j] <= products_x[j*ELEM_W +: ELEM_W];
            elem_y_q[j] <= products_y[j*ELEM_W +: ELEM_W];
         end
      end
   end

   // Accumulators and element index.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_x_q <= '0;
         acc_y_q <= '0;
         index_q <= '0;
      end else if (launch) begin
         acc_x_q <= '0;
         acc_y_q <= '0;
         index_q <= '0;
      end else if (state_q == S_ACC) begin
         acc_x_q <= acc_x_q + sext_elem(elem_x_q[index_q]);
         acc_y_q <= acc_y_q + sext_elem(elem_y_q[index_q]);
         index_q <= index_q + IDX_W'(1);
      end else if (state_q == S_OUT) begin
         index_q <= '0;
      end
   end

   magnitude_clamp #(
      .THRESHOLD (THRESHOLD)
   ) u_magnitude_clamp (
      .gx    (acc_x_q),
      .gy    (acc_y_q),
      .pixel (pixel_d)
   );

   // Result registers hold until the next output cycle; done marks the cycle after S_OUT.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pixel_out <= '0;
         gx_sum    <= '0;
         gy_sum    <= '0;
         done      <= 1'b0;
      end else begin
         done <= (state_q == S_OUT);
         if (state_q == S_OUT) begin
            pixel_out <= pixel_d;
            gx_sum    <= acc_x_q;
            gy_sum    <= acc_y_q;
         end
      end
   end

endmodule

// File: tb/tb_soma_gradiente.sv
// Self-checking bench for soma_gradiente: directed and random vectors against a
// plain-arithmetic reference (sum, abs, clamp/threshold) plus timing scenarios.
module tb_soma_gradiente;

   localparam int THR = 128;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic               start = 1'b0;
   logic [399:0]       products_x = '0;
   logic [399:0]       products_y = '0;
   logic [7:0]         pixel_out;
   logic signed [20:0] gx_sum, gy_sum;
   logic               busy, done;

   int checks = 0;
   int errors = 0;

   typedef int vec_t [25];
   vec_t px, py;

   soma_gradiente #(
      .THRESHOLD (THR)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .products_x (products_x),
      .products_y (products_y),
      .pixel_out  (pixel_out),
      .gx_sum     (gx_sum),
      .gy_sum     (gy_sum),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [399:0] pack_vec(input vec_t v);
      logic [399:0] r;
      int           t;
      r = '0;
      for (int i = 0; i < 25; i++) begin
         t = v[i];
         r[16*i +: 16] = t[15:0];
      end
      return r;
   endfunction

   function automatic int sum_vec(input vec_t v);
      int s = 0;
      foreach (v[i]) s += v[i];
      return s;
   endfunction

   function automatic int ref_pixel(input int gx, input int gy);
      int m;
      m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef EDGE_THRESHOLD_EN
      return (m > THR) ? 255 : 0;
`else
      return (m > 255) ? 255 : m;
`endif
   endfunction

   task automatic apply_vectors();
      products_x = pack_vec(px);
      products_y = pack_vec(py);
   endtask

   task automatic fill_random(input int amp);
      for (int i = 0; i < 25; i++) begin
         px[i] = int'($urandom_range(2 * amp)) - amp;
         py[i] = int'($urandom_range(2 * amp)) - amp;
      end
   endtask

   // Pulse start for one edge; returns at the falling edge after the launch edge.
   task automatic launch();
      @(negedge clock);
      apply_vectors();
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
   endtask

   // Counts rising edges until done is seen; the count starts at 'from'. Bounded.
   task automatic wait_done(input int from, output int lat);
      lat = from;
      while (lat < from + 100) begin
         @(posedge clock);
         lat++;
         @(negedge clock);
         if (done === 1'b1) break;
      end
   endtask

   task automatic test_reset();
      int lat, gxg, gyg;
      #1 reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got busy=%b done=%b expected 0 0", busy, done);
      end
      checks++;
      if (pixel_out !== 8'd0 || gx_sum !== 21'sd0 || gy_sum !== 21'sd0) begin
         errors++;
         $display("FAIL reset_outputs: got pix=%0d gx=%0d gy=%0d expected 0 0 0",
                  pixel_out, gx_sum, gy_sum);
      end
      // Release with start already high: the very first edge must launch.
      foreach (px[i]) begin px[i] = 2; py[i] = -1; end
      repeat (2) @(negedge clock);
      apply_vectors();
      reset = 1'b0;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_start: got busy=%b expected 1", busy);
      end
      wait_done(0, lat);
      gxg = gx_sum;
      gyg = gy_sum;
      checks++;
      if (lat !== 26 || gxg !== 50 || gyg !== -25) begin
         errors++;
         $display("FAIL reset_release_result: got lat=%0d gx=%0d gy=%0d expected 26 50 -25",
                  lat, gxg, gyg);
      end
   endtask

   task automatic test_directed();
      int lat, gxg, gyg, eg, ey, ep;
      for (int c = 0; c < 3; c++) begin
         foreach (px[i]) begin px[i] = 0; py[i] = 0; end
         case (c)
            0: foreach (px[i]) px[i] = 1;
            1: foreach (px[i]) begin px[i] = -32640; py[i] = 32640; end
            default: begin px[0] = 100; px[24] = -40; py[12] = -30; end
         endcase
         eg = sum_vec(px);
         ey = sum_vec(py);
         ep = ref_pixel(eg, ey);
         launch();
         wait_done(0, lat);
         gxg = gx_sum;
         gyg = gy_sum;
         checks++;
         if (lat !== 26) begin
            errors++;
            $display("FAIL directed%0d_latency: got %0d expected 26", c, lat);
         end
         checks++;
         if (gxg !== eg || gyg !== ey) begin
            errors++;
            $display("FAIL directed%0d_sums: got gx=%0d gy=%0d expected %0d %0d",
                     c, gxg, gyg, eg, ey);
         end
         checks++;
         if (int'(pixel_out) !== ep) begin
            errors++;
            $display("FAIL directed%0d_pixel: got %0d expected %0d", c, pixel_out, ep);
         end
         // One cycle later: pulse gone, results held.
         @(posedge clock);
         @(negedge clock);
         gxg = gx_sum;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || gxg !== eg) begin
            errors++;
            $display("FAIL directed%0d_hold: got done=%b busy=%b gx=%0d expected 0 0 %0d",
                     c, done, busy, gxg, eg);
         end
      end
   endtask

   task automatic test_random();
      int lat, gxg, gyg, eg, ey, ep;
      for (int k = 0; k < 8; k++) begin
         fill_random((k % 2 == 0) ? 12 : 32640);
         eg = sum_vec(px);
         ey = sum_vec(py);
         ep = ref_pixel(eg, ey);
         launch();
         wait_done(0, lat);
         gxg = gx_sum;
         gyg = gy_sum;
         checks++;
         if (lat !== 26 || gxg !== eg || gyg !== ey || int'(pixel_out) !== ep) begin
            errors++;
            $display("FAIL random%0d: got lat=%0d gx=%0d gy=%0d pix=%0d expected 26 %0d %0d %0d",
                     k, lat, gxg, gyg, pixel_out, eg, ey, ep);
         end
      end
   endtask

   task automatic test_restart_ignored();
      int lat, gxg, gyg, eg, ey, ep;
      fill_random(32640);
      eg = sum_vec(px);
      ey = sum_vec(py);
      ep = ref_pixel(eg, ey);
      launch();
      repeat (4) @(posedge clock);
      @(negedge clock);
      fill_random(32640);
      apply_vectors();
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      wait_done(5, lat);
      gxg = gx_sum;
      gyg = gy_sum;
      checks++;
      if (lat !== 26) begin
         errors++;
         $display("FAIL restart_latency: got %0d expected 26", lat);
      end
      checks++;
      if (gxg !== eg || gyg !== ey || int'(pixel_out) !== ep) begin
         errors++;
         $display("FAIL restart_result: got gx=%0d gy=%0d pix=%0d expected %0d %0d %0d",
                  gxg, gyg, pixel_out, eg, ey, ep);
      end
   endtask

   task automatic test_reset_mid();
      int lat, gxg, gyg, eg, ey;
      int seen_done;
      fill_random(32640);
      launch();
      repeat (12) @(posedge clock);
      #1 reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || gx_sum !== 21'sd0 || pixel_out !== 8'd0) begin
         errors++;
         $display("FAIL midreset_now: got busy=%b done=%b gx=%0d pix=%0d expected 0 0 0 0",
                  busy, done, gx_sum, pixel_out);
      end
      seen_done = 0;
      repeat (20) begin
         @(negedge clock);
         if (done !== 1'b0 || busy !== 1'b0) seen_done++;
      end
      checks++;
      if (seen_done !== 0) begin
         errors++;
         $display("FAIL midreset_quiet: got %0d active cycles expected 0", seen_done);
      end
      reset = 1'b0;
      fill_random(32640);
      eg = sum_vec(px);
      ey = sum_vec(py);
      launch();
      wait_done(0, lat);
      gxg = gx_sum;
      gyg = gy_sum;
      checks++;
      if (lat !== 26 || gxg !== eg || gyg !== ey || int'(pixel_out) !== ref_pixel(eg, ey)) begin
         errors++;
         $display("FAIL midreset_after: got lat=%0d gx=%0d gy=%0d pix=%0d expected 26 %0d %0d %0d",
                  lat, gxg, gyg, pixel_out, eg, ey, ref_pixel(eg, ey));
      end
   endtask

   task automatic test_back_to_back();
      int lat, gxg, gyg, eg, ey, ep;
      fill_random(32640);
      @(negedge clock);
      apply_vectors();
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      for (int k = 0; k < 4; k++) begin
         eg = sum_vec(px);
         ey = sum_vec(py);
         ep = ref_pixel(eg, ey);
         wait_done(0, lat);
         gxg = gx_sum;
         gyg = gy_sum;
         checks++;
         if (lat !== 26 || gxg !== eg || gyg !== ey || int'(pixel_out) !== ep) begin
            errors++;
            $display("FAIL b2b%0d: got lat=%0d gx=%0d gy=%0d pix=%0d expected 26 %0d %0d %0d",
                     k, lat, gxg, gyg, pixel_out, eg, ey, ep);
         end
         // Next vector must be in place for the relaunch edge right after done.
         fill_random((k % 2 == 0) ? 10 : 32640);
         apply_vectors();
         @(posedge clock);
         @(negedge clock);
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b%0d_relaunch: got busy=%b done=%b expected 1 0", k, busy, done);
         end
      end
      start = 1'b0;
      wait_done(0, lat);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_restart_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
